// File: rtl/pipeline_pkg.sv
// Shared definitions for the RV32I pipeline: opcodes, decode control bundle,
// immediate formats and the opcode-to-format mapping.
package pipeline_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // Control bundle carried from decode into execute.
    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic       funct7_5;
        logic       memread;
        logic       memwrite;
        logic       regwrite;
        logic       branch;
    } ctrl_t;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_t;

    // Immediate format implied by an opcode; unknown opcodes carry no immediate.
    function automatic imm_t imm_type_of(input logic [6:0] opcode);
        case (opcode)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: return IMM_I;
            OPC_STORE:                      return IMM_S;
            OPC_BRANCH:                     return IMM_B;
            OPC_LUI, OPC_AUIPC:             return IMM_U;
            OPC_JAL:                        return IMM_J;
            default:                        return IMM_NONE;
        endcase
    endfunction

endpackage

// File: rtl/regfile.sv
// Architectural register file: two combinational read ports, one clocked
// write port, x0 hardwired to zero, writeback value bypassed to same-cycle reads.
module regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   i_rs1,
    input  logic [AW-1:0]   i_rs2,
    input  logic            i_we,
    input  logic [AW-1:0]   i_wa,
    input  logic [XLEN-1:0] i_wd,
    output logic [XLEN-1:0] o_rd1,
    output logic [XLEN-1:0] o_rd2
);

    logic [XLEN-1:0] r_regs [NREGS];
    logic            w_wr_live;

    assign w_wr_live = i_we && (i_wa != '0);

    // Register array update; x0 is never written.
    // NOTE: this array is cleared by reset on purpose (architectural state must
    // start at zero), so it maps to flops rather than an un-resettable RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_live) begin
            r_regs[i_wa] <= i_wd;
        end
    end

    // Read ports: x0 reads zero, a live writeback to the same index wins.
    always_comb begin
        o_rd1 = (i_rs1 == '0) ? '0 : r_regs[i_rs1];
        o_rd2 = (i_rs2 == '0) ? '0 : r_regs[i_rs2];
        if (w_wr_live && (i_wa == i_rs1)) o_rd1 = i_wd;
        if (w_wr_live && (i_wa == i_rs2)) o_rd2 = i_wd;
    end

endmodule

// File: rtl/stage2_decode.sv
// Instruction-decode stage: field extraction, register read, immediate
// generation, load-use hazard detection and the ID/EX pipeline register.
module stage2_decode
    import pipeline_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0][XLEN-1:0] if_id,
    input  logic                 branch_cond,
    input  logic                 id_ex_memread_in,
    input  logic [4:0]           id_ex_rd_in,
    input  logic                 wb_en,
    input  logic [4:0]           wb_rd,
    input  logic [XLEN-1:0]      wb_data,
    output logic                 hazard,
    output logic                 id_ex_valid,
    output logic [XLEN-1:0]      id_ex_npc,
    output logic [XLEN-1:0]      id_ex_a,
    output logic [XLEN-1:0]      id_ex_b,
    output logic [XLEN-1:0]      id_ex_imm,
    output logic [4:0]           id_ex_rd,
    output ctrl_t                id_ex_ctrl
);

    logic [31:0]     w_inst;
    logic [6:0]      w_opcode;
    logic [4:0]      w_rd;
    logic [2:0]      w_funct3;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;
    logic [XLEN-1:0] w_imm;
    ctrl_t           w_ctrl;
    logic            w_uses_rs1;
    logic            w_uses_rs2;
    logic            w_hazard;
    logic            w_bubble;

    assign w_inst   = if_id[0];
    assign w_opcode = w_inst[6:0];
    assign w_rd     = w_inst[11:7];
    assign w_funct3 = w_inst[14:12];
    assign w_rs1    = w_inst[19:15];
    assign w_rs2    = w_inst[24:20];

    regfile #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_regfile (
        .clk   (clk),
        .rst_n (reset),
        .i_rs1 (w_rs1),
        .i_rs2 (w_rs2),
        .i_we  (wb_en),
        .i_wa  (wb_rd),
        .i_wd  (wb_data),
        .o_rd1 (w_rs1_val),
        .o_rd2 (w_rs2_val)
    );

    // Immediate generation selected by the opcode's instruction format.
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_imm = '0;
        case (imm_type_of(w_opcode))
            IMM_I:   w_imm = {{20{w_inst[31]}}, w_inst[31:20]};
            IMM_S:   w_imm = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
            IMM_B:   w_imm = {{19{w_inst[31]}}, w_inst[31], w_inst[7],
                              w_inst[30:25], w_inst[11:8], 1'b0};
            IMM_U:   w_imm = {w_inst[31:12], 12'b0};
            IMM_J:   w_imm = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12],
                              w_inst[20], w_inst[30:21], 1'b0};
            default: w_imm = '0;
        endcase
    end

    // Control flags and register-use decode; unknown opcodes raise no flags.
    always_comb begin
        w_ctrl          = '0;
        w_ctrl.opcode   = w_opcode;
        w_ctrl.funct3   = w_funct3;
        w_ctrl.funct7_5 = w_inst[30];
        case (w_opcode)
            OPC_OP, OPC_OP_IMM, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC:
                w_ctrl.regwrite = 1'b1;
            OPC_LOAD: begin
                w_ctrl.memread  = 1'b1;
                w_ctrl.regwrite = 1'b1;
            end
            OPC_STORE:  w_ctrl.memwrite = 1'b1;
            OPC_BRANCH: w_ctrl.branch   = 1'b1;
            default:    ;
        endcase
        w_uses_rs1 = !((w_opcode == OPC_LUI) || (w_opcode == OPC_AUIPC) ||
                       (w_opcode == OPC_JAL));
        w_uses_rs2 = (w_opcode == OPC_OP) || (w_opcode == OPC_STORE) ||
                     (w_opcode == OPC_BRANCH);
    end

    // Load-use stall request; a taken branch flushes this stage, so it never stalls.
    always_comb begin
        w_hazard = id_ex_memread_in && (id_ex_rd_in != 5'd0) &&
                   ((w_uses_rs1 && (w_rs1 == id_ex_rd_in)) ||
                    (w_uses_rs2 && (w_rs2 == id_ex_rd_in))) &&
                   !branch_cond;
    end

    assign hazard   = w_hazard;
    // Flush, stall and the fetch reset word all turn into a zeroed bubble.
    assign w_bubble = branch_cond || w_hazard || (w_inst == 32'd0);

    // ID/EX pipeline register.
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            id_ex_valid <= 1'b0;
            id_ex_npc   <= '0;
            id_ex_a     <= '0;
            id_ex_b     <= '0;
            id_ex_imm   <= '0;
            id_ex_rd    <= '0;
            id_ex_ctrl  <= '0;
        end else if (w_bubble) begin
            id_ex_valid <= 1'b0;
            id_ex_npc   <= '0;
            id_ex_a     <= '0;
            id_ex_b     <= '0;
            id_ex_imm   <= '0;
            id_ex_rd    <= '0;
            id_ex_ctrl  <= '0;
        end else begin
            id_ex_valid <= 1'b1;
            id_ex_npc   <= if_id[1];
            id_ex_a     <= w_rs1_val;
            id_ex_b     <= w_rs2_val;
            id_ex_imm   <= w_imm;
            id_ex_rd    <= w_rd;
            id_ex_ctrl  <= w_ctrl;
        end
    end

endmodule

// File: tb/tb_stage2_decode.sv
// Directed bench for stage2_decode: hand-encoded instructions with
// hand-computed operands, immediates, control bundles and hazard values.
module tb_stage2_decode;
    import pipeline_pkg::*;

    logic             clk;
    logic             reset;
    logic [1:0][31:0] if_id;
    logic             branch_cond;
    logic             id_ex_memread_in;
    logic [4:0]       id_ex_rd_in;
    logic             wb_en;
    logic [4:0]       wb_rd;
    logic [31:0]      wb_data;
    logic             hazard;
    logic             id_ex_valid;
    logic [31:0]      id_ex_npc;
    logic [31:0]      id_ex_a;
    logic [31:0]      id_ex_b;
    logic [31:0]      id_ex_imm;
    logic [4:0]       id_ex_rd;
    ctrl_t            id_ex_ctrl;

    int n_vec = 0;
    int n_err = 0;

    // Hand-encoded instructions.
    localparam logic [31:0] ADD_6_5_0  = 32'h0002_8333; // add  x6,x5,x0
    localparam logic [31:0] ADD_8_7_2  = 32'h0023_8433; // add  x8,x7,x2
    localparam logic [31:0] ADD_6_0_0  = 32'h0000_0333; // add  x6,x0,x0
    localparam logic [31:0] ADDI_1_M1  = 32'hFFF0_0093; // addi x1,x0,-1
    localparam logic [31:0] SW_2_12_1  = 32'h0020_A623; // sw   x2,12(x1)
    localparam logic [31:0] LUI_7      = 32'h0003_83B7; // lui  x7,0x38 (rs1 field = 7)
    localparam logic [31:0] BEQ_M4     = 32'hFE00_0EE3; // beq  x0,x0,-4
    localparam logic [31:0] JAL_8      = 32'h0080_006F; // jal  x0,8

    stage2_decode dut (
        .clk              (clk),
        .reset            (reset),
        .if_id            (if_id),
        .branch_cond      (branch_cond),
        .id_ex_memread_in (id_ex_memread_in),
        .id_ex_rd_in      (id_ex_rd_in),
        .wb_en            (wb_en),
        .wb_rd            (wb_rd),
        .wb_data          (wb_data),
        .hazard           (hazard),
        .id_ex_valid      (id_ex_valid),
        .id_ex_npc        (id_ex_npc),
        .id_ex_a          (id_ex_a),
        .id_ex_b          (id_ex_b),
        .id_ex_imm        (id_ex_imm),
        .id_ex_rd         (id_ex_rd),
        .id_ex_ctrl       (id_ex_ctrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ctrl_t mk_ctrl(input logic [6:0] op, input logic [2:0] f3,
                                      input logic f7, input logic mr, input logic mw,
                                      input logic rw, input logic br);
        ctrl_t c;
        c = '{opcode: op, funct3: f3, funct7_5: f7, memread: mr,
              memwrite: mw, regwrite: rw, branch: br};
        return c;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset            = 1'b0;
        if_id[0]         = 32'd0;
        if_id[1]         = 32'd0;
        branch_cond      = 1'b0;
        id_ex_memread_in = 1'b0;
        id_ex_rd_in      = 5'd0;
        wb_en            = 1'b0;
        wb_rd            = 5'd0;
        wb_data          = 32'd0;

        // Reset state.
        #12;
        check("rst_valid",  {31'd0, id_ex_valid}, 32'd0);
        check("rst_a",      id_ex_a, 32'd0);
        check("rst_ctrl",   {18'd0, id_ex_ctrl}, 32'd0);
        check("rst_hazard", {31'd0, hazard}, 32'd0);

        tick();
        reset = 1'b1;

        // Writeback x5 while decoding a reader of x5 in the same cycle.
        if_id[0] = ADD_6_5_0; if_id[1] = 32'h104;
        wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
        #1 check("byp_hazard", {31'd0, hazard}, 32'd0);
        tick();
        check("byp_valid", {31'd0, id_ex_valid}, 32'd1);
        check("byp_a",     id_ex_a, 32'hDEADBEEF);
        check("byp_b",     id_ex_b, 32'd0);
        check("byp_rd",    {27'd0, id_ex_rd}, 32'd6);
        check("byp_npc",   id_ex_npc, 32'h104);
        check("byp_ctrl",  {18'd0, id_ex_ctrl}, {18'd0, mk_ctrl(OPC_OP, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0)});

        // Same instruction, now read back from the array.
        wb_en = 1'b0;
        tick();
        check("arr_a", id_ex_a, 32'hDEADBEEF);

        // x7 = 0x700 while decoding addi x1,x0,-1.
        if_id[0] = ADDI_1_M1;
        wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'h700;
        tick();
        check("addi_imm",  id_ex_imm, 32'hFFFFFFFF);
        check("addi_ctrl", {18'd0, id_ex_ctrl}, {18'd0, mk_ctrl(OPC_OP_IMM, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0)});

        // x2 = 0x22 bypassed into a store's rs2.
        if_id[0] = SW_2_12_1;
        wb_rd = 5'd2; wb_data = 32'h22;
        tick();
        check("sw_imm",  id_ex_imm, 32'd12);
        check("sw_b",    id_ex_b, 32'h22);
        check("sw_ctrl", {18'd0, id_ex_ctrl}, {18'd0, mk_ctrl(OPC_STORE, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)});

        // Load-use on rs1: lw x7 in EX, add x8,x7,x2 in decode.
        wb_en = 1'b0;
        if_id[0] = ADD_8_7_2; if_id[1] = 32'h200;
        id_ex_memread_in = 1'b1; id_ex_rd_in = 5'd7;
        #1 check("lu_hazard", {31'd0, hazard}, 32'd1);
        tick();
        check("lu_valid", {31'd0, id_ex_valid}, 32'd0);
        check("lu_ctrl",  {18'd0, id_ex_ctrl}, 32'd0);
        check("lu_a",     id_ex_a, 32'd0);
        // EX now holds the bubble; the same add re-presents and issues.
        id_ex_memread_in = 1'b0; id_ex_rd_in = 5'd0;
        #1 check("lu_clear", {31'd0, hazard}, 32'd0);
        tick();
        check("lu_iss_valid", {31'd0, id_ex_valid}, 32'd1);
        check("lu_iss_a",     id_ex_a, 32'h700);
        check("lu_iss_b",     id_ex_b, 32'h22);
        check("lu_iss_rd",    {27'd0, id_ex_rd}, 32'd8);
        check("lu_iss_npc",   id_ex_npc, 32'h200);

        // LUI does not read rs1 even though its rs1 field matches.
        if_id[0] = LUI_7;
        id_ex_memread_in = 1'b1; id_ex_rd_in = 5'd7;
        #1 check("lui_hazard", {31'd0, hazard}, 32'd0);
        tick();
        check("lui_valid", {31'd0, id_ex_valid}, 32'd1);
        check("lui_imm",   id_ex_imm, 32'h0003_8000);

        // Load to x0 never stalls.
        if_id[0] = ADD_8_7_2;
        id_ex_rd_in = 5'd0;
        #1 check("rd0_hazard", {31'd0, hazard}, 32'd0);

        // Load-use on rs2, then a taken branch overrides it.
        id_ex_rd_in = 5'd2;
        #1 check("rs2_hazard", {31'd0, hazard}, 32'd1);
        branch_cond = 1'b1;
        #1 check("br_hazard", {31'd0, hazard}, 32'd0);
        tick();
        check("br_valid", {31'd0, id_ex_valid}, 32'd0);
        check("br_ctrl",  {18'd0, id_ex_ctrl}, 32'd0);
        branch_cond = 1'b0; id_ex_memread_in = 1'b0; id_ex_rd_in = 5'd0;

        // Branch immediate: beq x0,x0,-4.
        if_id[0] = BEQ_M4;
        tick();
        check("beq_imm",  id_ex_imm, 32'hFFFFFFFC);
        check("beq_ctrl", {18'd0, id_ex_ctrl}, {18'd0, mk_ctrl(OPC_BRANCH, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1)});

        // Jump immediate: jal x0,8.
        if_id[0] = JAL_8;
        tick();
        check("jal_imm", id_ex_imm, 32'd8);

        // Writes to x0 are dropped, both via bypass and in the array.
        if_id[0] = ADD_6_0_0;
        wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234;
        tick();
        check("x0_byp_a", id_ex_a, 32'd0);
        wb_en = 1'b0;
        tick();
        check("x0_arr_a", id_ex_a, 32'd0);

        // Fetch reset word decodes as a bubble.
        if_id[0] = 32'd0;
        tick();
        check("zero_valid", {31'd0, id_ex_valid}, 32'd0);

        // Reset mid-run clears ID/EX immediately and wipes the register file.
        if_id[0] = ADD_6_5_0; if_id[1] = 32'h300;
        tick();
        check("pre_rst_a", id_ex_a, 32'hDEADBEEF);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, id_ex_valid}, 32'd0);
        check("mid_rst_a",     id_ex_a, 32'd0);
        check("mid_rst_npc",   id_ex_npc, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        check("post_rst_valid", {31'd0, id_ex_valid}, 32'd1);
        check("post_rst_x5",    id_ex_a, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
